aes_ecb_scheduler: RTL and testbench

Two-channel round-robin scheduler that shares one `AES_ecb_top` AES-256 ECB core between two block requesters. Holds a 256-bit key per channel. Streams the granted channel's key into the core's key expansion only when the loaded key differs from the one needed. Issues `start`, waits for `done`, and returns the ciphertext to the owning channel over a valid/ready response.

---
 rtl/aes_ecb_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_aes_ecb_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ecb_scheduler.sv
// aes_ecb_scheduler
//   Shares one AES-256 ECB core between two block requesters with round-robin
//   arbitration. Keeps a 256-bit key per channel and streams the granted
//   channel's key into the core only when the core does not already hold it.
//
//   Optional feature macro: AES_SCHED_KEY_CACHE_EN
//     defined   -> key reload skipped while the loaded key still matches
//     undefined -> every block streams all 8 key words before start
//
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   cfg_wr/cfg_ch/cfg_key     : key write (honoured while cfg_ready=1)
//   cfg_ready                 : scheduler idle, key writes accepted
//   chN_req/chN_pt/chN_ack    : per-channel block request, plaintext, take pulse
//   chN_rsp_valid/chN_rsp_ready, rsp_ct : per-channel ciphertext response
//   aes_*                     : connection to the shared AES core
module aes_ecb_scheduler (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_wr,
    input  logic         cfg_ch,
    input  logic [255:0] cfg_key,
    output logic         cfg_ready,
    input  logic         ch0_req,
    input  logic         ch1_req,
    input  logic [127:0] ch0_pt,
    input  logic [127:0] ch1_pt,
    output logic         ch0_ack,
    output logic         ch1_ack,
    output logic         ch0_rsp_valid,
    output logic         ch1_rsp_valid,
    input  logic         ch0_rsp_ready,
    input  logic         ch1_rsp_ready,
    output logic [127:0] rsp_ct,
    output logic         aes_start,
    output logic [31:0]  aes_key_word,
    output logic         aes_valid_word,
    output logic [127:0] aes_plain_text,
    input  logic         aes_done,
    input  logic [127:0] aes_cipher_text
);

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_START, S_WAIT, S_RESP} state_t;
    // Element 7 holds key word 0 (bits [255:224]), so word k is element 7-k.
    typedef logic [7:0][31:0] key_t;

    state_t        state_q, state_d;
    key_t          key_q [2];
    key_t          key_d [2];
    logic          last_grant_q, last_grant_d;
    logic          grant_q, grant_d;
    logic          loaded_ch_q, loaded_ch_d;
    logic          loaded_vld_q, loaded_vld_d;
    logic [2:0]    kcnt_q, kcnt_d;
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    rsp_valid_q, rsp_valid_d;
    logic          start_q, start_d;
    logic          valid_word_q, valid_word_d;
    logic [31:0]   key_word_q, key_word_d;
    logic [127:0]  pt_q, pt_d;
    logic [127:0]  ct_q, ct_d;
    logic          cfg_ready_q, cfg_ready_d;

    logic [1:0]    req;
    logic          gnt;
    logic          vld_after_cfg;
    logic          reload;
    logic          rsp_ready_g;

    assign req         = {ch1_req, ch0_req};
    assign rsp_ready_g = grant_q ? ch1_rsp_ready : ch0_rsp_ready;

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        loaded_ch_d   = loaded_ch_q;
        loaded_vld_d  = loaded_vld_q;
        kcnt_d        = kcnt_q;
        ack_d         = 2'b00;
        rsp_valid_d   = rsp_valid_q;
        start_d       = 1'b0;
        valid_word_d  = 1'b0;
        key_word_d    = 32'h0;
        pt_d          = pt_q;
        ct_d          = ct_q;
        gnt           = 1'b0;
        vld_after_cfg = loaded_vld_q;
        reload        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Key write lands first so a same-cycle grant sees the new key.
                if (cfg_wr && cfg_ready_q) begin
                    key_d[cfg_ch] = cfg_key;
                    if (cfg_ch == loaded_ch_q) vld_after_cfg = 1'b0;
                end
                loaded_vld_d = vld_after_cfg;
                if (req != 2'b00) begin
                    // Tie goes to the channel that was not served last.
                    gnt          = (req == 2'b11) ? ~last_grant_q : req[1];
                    reload       = !vld_after_cfg || (loaded_ch_q != gnt);
                    grant_d      = gnt;
                    last_grant_d = gnt;
                    pt_d         = gnt ? ch1_pt : ch0_pt;
                    ack_d        = gnt ? 2'b10 : 2'b01;
                    if (reload) begin
                        state_d      = S_KEY;
                        kcnt_d       = 3'd0;
                        valid_word_d = 1'b1;
                        key_word_d   = key_d[gnt][7];
                    end else begin
                        state_d = S_START;
                        start_d = 1'b1;
                    end
                end
            end
            S_KEY: begin
                if (kcnt_q == 3'd7) begin
                    loaded_ch_d = grant_q;
`ifdef AES_SCHED_KEY_CACHE_EN
                    loaded_vld_d = 1'b1;
`else
                    loaded_vld_d = 1'b0;
`endif
                    state_d = S_START;
                    start_d = 1'b1;
                end else begin
                    // Registered output: present word k+1 while word k is on the bus.
                    kcnt_d       = kcnt_q + 3'd1;
                    valid_word_d = 1'b1;
                    key_word_d   = key_q[grant_q][3'd6 - kcnt_q];
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (aes_done) begin
                    ct_d        = aes_cipher_text;
                    rsp_valid_d = grant_q ? 2'b10 : 2'b01;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_g) begin
                    rsp_valid_d = 2'b00;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cfg_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            key_q[0]     <= '0;
            key_q[1]     <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            loaded_ch_q  <= 1'b0;
            loaded_vld_q <= 1'b0;
            kcnt_q       <= 3'd0;
            ack_q        <= 2'b00;
            rsp_valid_q  <= 2'b00;
            start_q      <= 1'b0;
            valid_word_q <= 1'b0;
            key_word_q   <= 32'h0;
            pt_q         <= 128'h0;
            ct_q         <= 128'h0;
            cfg_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            loaded_ch_q  <= loaded_ch_d;
            loaded_vld_q <= loaded_vld_d;
            kcnt_q       <= kcnt_d;
            ack_q        <= ack_d;
            rsp_valid_q  <= rsp_valid_d;
            start_q      <= start_d;
            valid_word_q <= valid_word_d;
            key_word_q   <= key_word_d;
            pt_q         <= pt_d;
            ct_q         <= ct_d;
            cfg_ready_q  <= cfg_ready_d;
        end
    end

    assign cfg_ready      = cfg_ready_q;
    assign ch0_ack        = ack_q[0];
    assign ch1_ack        = ack_q[1];
    assign ch0_rsp_valid  = rsp_valid_q[0];
    assign ch1_rsp_valid  = rsp_valid_q[1];
    assign rsp_ct         = ct_q;
    assign aes_start      = start_q;
    assign aes_key_word   = key_word_q;
    assign aes_valid_word = valid_word_q;
    assign aes_plain_text = pt_q;

endmodule

// File: tb/tb_aes_ecb_scheduler.sv
// Bench for aes_ecb_scheduler: a stand-in AES core, a transaction-level model
// of the scheduler, directed scenarios and a randomized phase.
module tb_aes_ecb_scheduler;

`ifdef AES_SCHED_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk, reset;
    logic         cfg_wr, cfg_ch, cfg_ready;
    logic [255:0] cfg_key;
    logic         ch0_req, ch1_req, ch0_ack, ch1_ack;
    logic [127:0] ch0_pt, ch1_pt, rsp_ct;
    logic         ch0_rsp_valid, ch1_rsp_valid, ch0_rsp_ready, ch1_rsp_ready;
    logic         aes_start, aes_valid_word, aes_done;
    logic [31:0]  aes_key_word;
    logic [127:0] aes_plain_text, aes_cipher_text;

    aes_ecb_scheduler dut (
        .clk(clk), .reset(reset),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_key(cfg_key), .cfg_ready(cfg_ready),
        .ch0_req(ch0_req), .ch1_req(ch1_req), .ch0_pt(ch0_pt), .ch1_pt(ch1_pt),
        .ch0_ack(ch0_ack), .ch1_ack(ch1_ack),
        .ch0_rsp_valid(ch0_rsp_valid), .ch1_rsp_valid(ch1_rsp_valid),
        .ch0_rsp_ready(ch0_rsp_ready), .ch1_rsp_ready(ch1_rsp_ready),
        .rsp_ct(rsp_ct),
        .aes_start(aes_start), .aes_key_word(aes_key_word), .aes_valid_word(aes_valid_word),
        .aes_plain_text(aes_plain_text), .aes_done(aes_done), .aes_cipher_text(aes_cipher_text)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Stand-in cipher: exact FIPS-197 C.3 answer for that vector, a keyed mix otherwise.
    function automatic logic [127:0] fake_aes(input logic [255:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return p ^ k[255:128] ^ {k[119:0], k[127:120]} ^ 128'h5a5a_1234_a5a5_4321_0f0f_7777_f0f0_9999;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stand-in AES core ----------------
    logic [255:0] core_key, lat_key;
    logic [127:0] lat_pt;
    bit           core_busy, core_rst;
    int           core_cnt;

    initial begin
        aes_done = 1'b0; aes_cipher_text = '0; core_key = '0; core_busy = 0; core_cnt = 0;
        forever begin
            @(negedge clk);
            core_rst = reset;
            @(posedge clk);
            #1;
            aes_done = 1'b0;
            aes_cipher_text = rand128();
            if (core_rst) begin
                core_busy = 0;
                core_key = '0;
            end else begin
                if (core_busy) begin
                    core_cnt--;
                    if (core_cnt == 0) begin
                        aes_done = 1'b1;
                        aes_cipher_text = fake_aes(lat_key, lat_pt);
                        core_busy = 0;
                    end
                end
                if (aes_valid_word) core_key = {core_key[223:0], aes_key_word};
                if (aes_start) begin
                    core_busy = 1;
                    core_cnt = $urandom_range(3, 8);
                    lat_pt = aes_plain_text;
                    lat_key = core_key;
                end
            end
        end
    end

    // ---------------- transaction-level model + compare ----------------
    logic [255:0] mkey [2];
    bit           mlast, mvld, mch, idle_cur, rst_prev, inflight, owner;
    bit           grant_pend, gch, greload, accepted;
    logic [127:0] gpt, exp_ct;
    logic [255:0] gkey;
    longint       cyc = 0, exp_start = -1, exp_rsp = -1;
    logic [31:0]  wq [$];
    logic [31:0]  seen [$];
    logic [31:0]  wexp;

    always @(negedge clk) begin
        cyc++;
        accepted = 0;
        if (reset) begin
            mkey[0] = '0; mkey[1] = '0; mlast = 1; mvld = 0; mch = 0;
            inflight = 0; grant_pend = 0; wq.delete();
            exp_start = -1; exp_rsp = -1; idle_cur = 1; rst_prev = 1;
        end else begin
            if (rst_prev) begin
                chk("reset_ctl", {cfg_ready, ch0_ack, ch1_ack, ch0_rsp_valid, ch1_rsp_valid,
                                  aes_start, aes_valid_word, aes_key_word}, '0);
                chk("reset_data", {rsp_ct, aes_plain_text}, '0);
            end
            chk("cfg_ready", cfg_ready, idle_cur && !rst_prev);

            if (grant_pend) begin
                chk("ack", {ch1_ack, ch0_ack}, gch ? 2'b10 : 2'b01);
                chk("plain_text", aes_plain_text, gpt);
                inflight = 1; owner = gch; exp_ct = fake_aes(gkey, gpt); exp_rsp = -1;
                exp_start = cyc + (greload ? 8 : 0);
                if (greload) for (int i = 0; i < 8; i++) wq.push_back(gkey[255 - 32*i -: 32]);
                grant_pend = 0;
            end else begin
                chk("no_ack", {ch1_ack, ch0_ack}, 2'b00);
            end

            if (aes_valid_word) begin
                seen.push_back(aes_key_word);
                chk("key_word_expected", wq.size() != 0, 1'b1);
                if (wq.size() != 0) begin
                    wexp = wq.pop_front();
                    chk("key_word", aes_key_word, wexp);
                end
            end
            chk("start_timing", aes_start, cyc == exp_start);
            if (aes_start) begin
                chk("words_before_start", wq.size(), 0);
                chk("start_pt", aes_plain_text, gpt);
            end

            if (inflight && aes_done) exp_rsp = cyc + 1;
            if (inflight && exp_rsp >= 0 && cyc >= exp_rsp) begin
                chk("rsp_valid", {ch1_rsp_valid, ch0_rsp_valid}, owner ? 2'b10 : 2'b01);
                chk("rsp_ct", rsp_ct, exp_ct);
                if (owner ? ch1_rsp_ready : ch0_rsp_ready) begin
                    inflight = 0; accepted = 1; exp_rsp = -1;
                end
            end else begin
                chk("no_rsp_valid", {ch1_rsp_valid, ch0_rsp_valid}, 2'b00);
            end

            if (cfg_wr && cfg_ready) begin
                mkey[cfg_ch] = cfg_key;
                if (cfg_ch == mch) mvld = 0;
            end
            if (idle_cur && (ch0_req || ch1_req)) begin
                gch = (ch0_req && ch1_req) ? !mlast : ch1_req;
                mlast = gch;
                greload = !(CACHE && mvld && mch == gch);
                if (greload) begin mvld = 1; mch = gch; end
                gpt = gch ? ch1_pt : ch0_pt;
                gkey = mkey[gch];
                grant_pend = 1;
                idle_cur = 0;
            end
            if (accepted) idle_cur = 1;
            rst_prev = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic sig_sel(input int s);
        case (s)
            0: return ch0_ack;
            1: return ch1_ack;
            2: return ch0_rsp_valid;
            3: return ch1_rsp_valid;
            4: return cfg_ready;
            default: return aes_start;
        endcase
    endfunction

    task automatic wait_for(input int s, input string nm);
        int n = 0;
        while (!sig_sel(s) && n < 300) begin tick(); n++; end
        chk(nm, sig_sel(s), 1'b1);
    endtask

    task automatic cfg_write(input bit ch, input logic [255:0] k);
        wait_for(4, "cfg_ready_wait");
        cfg_wr = 1; cfg_ch = ch; cfg_key = k;
        tick();
        cfg_wr = 0;
    endtask

    task automatic request(input bit ch, input logic [127:0] pt);
        if (ch) begin ch1_pt = pt; ch1_req = 1; end
        else    begin ch0_pt = pt; ch0_req = 1; end
        wait_for(ch ? 1 : 0, "ack_wait");
        if (ch) ch1_req = 0; else ch0_req = 0;
    endtask

    logic [255:0] ka, kb, kc;
    logic [255:0] pool [3];
    logic [127:0] p;
    logic [31:0]  w;
    int           log_q [$];
    int           vcnt, acnt, ctok, rc;

    initial begin
        reset = 1; cfg_wr = 0; cfg_ch = 0; cfg_key = '0;
        ch0_req = 0; ch1_req = 0; ch0_pt = '0; ch1_pt = '0;
        ch0_rsp_ready = 1; ch1_rsp_ready = 1;
        ka = {rand128(), rand128()}; kb = {rand128(), rand128()};
        tick(3);
        reset = 0;
        tick();
        chk("cfg_ready_after_reset", cfg_ready, 1'b1);

        // FIPS-197 C.3 vector on ch0
        cfg_write(0, FIPS_KEY);
        seen.delete();
        request(0, FIPS_PT);
        wait_for(2, "fips_rsp");
        chk("fips_ct", rsp_ct, FIPS_CT);
        chk("fips_ch1_quiet", ch1_rsp_valid, 1'b0);
        chk("fips_nwords", seen.size(), 8);
        chk("fips_word0", seen[0], 32'h00010203);
        chk("fips_word7", seen[7], 32'h1c1d1e1f);

        // second ch0 block with the same key
        seen.delete();
        request(0, rand128());
        wait_for(2, "same_key_rsp");
        chk("same_key_nwords", seen.size(), CACHE ? 0 : 8);

        // alternating grants, both requesters held high
        reset = 1; tick(); reset = 0;
        cfg_write(0, ka);
        cfg_write(1, kb);
        seen.delete(); log_q.delete();
        ch0_pt = rand128(); ch1_pt = rand128(); ch0_req = 1; ch1_req = 1;
        for (int n = 0; n < 400 && log_q.size() < 4; n++) begin
            tick();
            if (ch0_ack) begin log_q.push_back(0); ch0_pt = rand128(); end
            if (ch1_ack) begin log_q.push_back(1); ch1_pt = rand128(); end
        end
        ch0_req = 0; ch1_req = 0;
        chk("alt_count", log_q.size(), 4);
        for (int i = 0; i < log_q.size(); i++) chk("alt_order", log_q[i], i % 2);
        wait_for(4, "alt_drain");
        chk("alt_nwords", seen.size(), 32);

        // key write in the same idle cycle as a ch0 request
        request(0, rand128());
        wait_for(4, "pre_cfg_idle");
        seen.delete();
        kc = {rand128(), rand128()};
        p = rand128();
        cfg_wr = 1; cfg_ch = 0; cfg_key = kc; ch0_req = 1; ch0_pt = p;
        tick();
        cfg_wr = 0;
        chk("cfg_req_ack", ch0_ack, 1'b1);
        ch0_req = 0;
        wait_for(2, "cfg_req_rsp");
        chk("cfg_req_nwords", seen.size(), 8);
        w = kc[255:224];
        chk("cfg_req_word0", seen[0], w);
        chk("cfg_req_ct", rsp_ct, fake_aes(kc, p));

        // ch1 response back-pressured for 20 cycles while ch0 waits
        ch1_rsp_ready = 0;
        p = rand128();
        request(1, p);
        wait_for(3, "bp_rsp");
        ch0_req = 1; ch0_pt = rand128();
        vcnt = 0; acnt = 0; ctok = 0;
        repeat (20) begin
            tick();
            vcnt += int'(ch1_rsp_valid);
            acnt += int'(ch0_ack);
            ctok += int'(rsp_ct == fake_aes(kb, p));
        end
        chk("bp_valid_held", vcnt, 20);
        chk("bp_no_grant", acnt, 0);
        chk("bp_ct_held", ctok, 20);
        ch1_rsp_ready = 1;
        wait_for(0, "bp_ch0_ack");
        ch0_req = 0;
        wait_for(2, "bp_ch0_rsp");

        // reset while the core is busy
        request(0, rand128());
        wait_for(5, "rst_start");
        tick(2);
        reset = 1; tick(); reset = 0;
        rc = 0;
        repeat (30) begin
            tick();
            rc += int'(ch0_rsp_valid | ch1_rsp_valid);
        end
        chk("rst_no_rsp", rc, 0);
        cfg_write(0, ka);
        seen.delete();
        request(0, rand128());
        wait_for(2, "rst_after_rsp");
        chk("rst_reload_nwords", seen.size(), 8);

        // randomized traffic, key writes and back-pressure
        pool[0] = ka; pool[1] = kb; pool[2] = kc;
        for (int c = 0; c < 3000; c++) begin
            if (ch0_ack) begin ch0_req = 1'($urandom_range(0, 1)); ch0_pt = rand128(); end
            else if (!ch0_req && $urandom_range(0, 9) < 3) begin ch0_req = 1; ch0_pt = rand128(); end
            if (ch1_ack) begin ch1_req = 1'($urandom_range(0, 1)); ch1_pt = rand128(); end
            else if (!ch1_req && $urandom_range(0, 9) < 3) begin ch1_req = 1; ch1_pt = rand128(); end
            ch0_rsp_ready = ($urandom_range(0, 3) != 0);
            ch1_rsp_ready = ($urandom_range(0, 3) != 0);
            cfg_wr  = ($urandom_range(0, 9) == 0);
            cfg_ch  = 1'($urandom_range(0, 1));
            cfg_key = pool[$urandom_range(0, 2)];
            tick();
        end
        ch0_req = 0; ch1_req = 0; cfg_wr = 0;
        ch0_rsp_ready = 1; ch1_rsp_ready = 1;
        tick();
        wait_for(4, "final_drain");
        tick(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
